// File: rtl/mlp_load_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
//   Shared definitions for the MLP load sequencer: the sequencer FSM state
//   encoding, the geometry of the load phases and the load_type encoding seen
//   by the accelerator's load interface.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package mlp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_IN  = 3'd1,
        ST_LOAD_W   = 3'd2,
        ST_GAP      = 3'd3,
        ST_WAIT_RES = 3'd4
    } seq_state_t;

    // Input phase: ROWS rows of WORDS_PER_ROW words.
    // Weight phase: WEIGHT_GROUPS groups of ROWS words, once per layer.
    localparam int ROWS          = 16;
    localparam int WORDS_PER_ROW = 8;
    localparam int WEIGHT_GROUPS = 8;

    localparam logic LOAD_TYPE_INPUT  = 1'b1;
    localparam logic LOAD_TYPE_WEIGHT = 1'b0;

    // The host stream is only open in the two load states.
    function automatic logic is_load_state(input seq_state_t s);
        return (s == ST_LOAD_IN) || (s == ST_LOAD_W);
    endfunction

endpackage

// File: rtl/mlp_load_sequencer_counter.sv
// -----------------------------------------------------------------------------
// counter
//   Generic up-counter with synchronous clear and count enable. Clear has
//   priority over enable. The count wraps naturally at 2**WIDTH.
//   Ports:
//     clk    in   clock
//     rst    in   synchronous active-high reset
//     clr    in   synchronous clear to zero
//     en     in   increment by one this cycle
//     count  out  WIDTH-bit current count
// -----------------------------------------------------------------------------
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mlp_load_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_load_sequencer
//   Upstream control stage for MLP_acc_top. Accepts a valid/ready stream of
//   32-bit host words and replays them onto the accelerator load interface
//   with the control fields sequenced as: the layer-0 input matrix (16 rows x
//   8 words), then NUM_LAYERS layers of weights (8 groups x 16 rows), with
//   LAYER_GAP idle cycles after every layer. It then counts RESULT_WORDS
//   result beats and pulses done_o.
//
//   Ports:
//     clk                  in   clock
//     rst                  in   synchronous active-high reset
//     start_i              in   job start, sampled only in IDLE
//     busy_o               out  job in progress
//     done_o               out  one-cycle completion pulse
//     s_valid_i            in   host word valid
//     s_ready_o            out  sequencer accepts a word (state-only)
//     s_data_i             in   32-bit host word
//     load_en_o            out  one cycle per transferred word
//     load_payload_o       out  registered copy of the accepted word
//     load_type_o          out  1 = input, 0 = weight
//     input_load_number_o  out  row index 0..15
//     layer_number_o       out  layer 0..7
//     weight_number_o      out  weight group 0..7
//     result_valid_i       in   accelerator result beat
// -----------------------------------------------------------------------------
module mlp_load_sequencer
    import mlp_pkg::*;
#(
    parameter int NUM_LAYERS   = 8,
    parameter int LAYER_GAP    = 4,
    parameter int RESULT_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [31:0] s_data_i,
    output logic        load_en_o,
    output logic [31:0] load_payload_o,
    output logic        load_type_o,
    output logic [3:0]  input_load_number_o,
    output logic [2:0]  layer_number_o,
    output logic [2:0]  weight_number_o,
    input  logic        result_valid_i
);

    localparam int GAP_W = $clog2(LAYER_GAP + 1);

    localparam logic [2:0]       LAST_WORD  = 3'(WORDS_PER_ROW - 1);
    localparam logic [3:0]       LAST_ROW   = 4'(ROWS - 1);
    localparam logic [2:0]       LAST_GROUP = 3'(WEIGHT_GROUPS - 1);
    localparam logic [2:0]       LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(LAYER_GAP - 1);
    localparam logic [7:0]       RES_LAST   = 8'(RESULT_WORDS - 1);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    seq_state_t       state;
    seq_state_t       state_next;

    logic [2:0]       word_cnt;
    logic [3:0]       row;
    logic [2:0]       wnum;
    logic [2:0]       layer;

    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       res_cnt;

    logic             accept;
    logic             last_in_word;
    logic             last_w_word;
    logic             gap_done;
    logic             res_done;
    logic             gap_en;
    logic             gap_clr;
    logic             res_en;
    logic             res_clr;

    // -------------------------------------------------------------------------
    // Phase-boundary decodes
    // -------------------------------------------------------------------------
    assign accept       = s_valid_i && s_ready_o;
    assign last_in_word = (word_cnt == LAST_WORD) && (row == LAST_ROW);
    assign last_w_word  = (row == LAST_ROW) && (wnum == LAST_GROUP);
    // The gap counter starts at 0 on entry, so the last GAP cycle sees
    // LAYER_GAP-1 and exactly LAYER_GAP cycles are spent in GAP.
    assign gap_done     = (state == ST_GAP) && (gap_cnt == GAP_LAST);
    // The final result beat is the one that arrives while RESULT_WORDS-1
    // beats have already been counted.
    assign res_done     = (state == ST_WAIT_RES) && result_valid_i && (res_cnt == RES_LAST);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every always_ff reads the pre-edge value of every register regardless
    // of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so that no path leaves
    // it unassigned; without it this block would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_i) state_next = ST_LOAD_IN;
            end
            ST_LOAD_IN: begin
                if (accept && last_in_word) state_next = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                if (accept && last_w_word) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_next = (layer == LAST_LAYER) ? ST_WAIT_RES : ST_LOAD_W;
                end
            end
            ST_WAIT_RES: begin
                if (res_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state-decoded outputs and counter controls
    // -------------------------------------------------------------------------
    always_comb begin
        // s_ready_o depends on state only, never on s_valid_i.
        s_ready_o = is_load_state(state);
        busy_o    = (state != ST_IDLE);
        gap_en    = (state == ST_GAP);
        res_en    = (state == ST_WAIT_RES) && result_valid_i;
        // Each counter is cleared on the edge that enters its state.
        gap_clr   = (state != ST_GAP)      && (state_next == ST_GAP);
        res_clr   = (state != ST_WAIT_RES) && (state_next == ST_WAIT_RES);
    end

    // -------------------------------------------------------------------------
    // Load position counters
    // -------------------------------------------------------------------------
    // All counters wrap naturally: after the last input word row/word_cnt are
    // back at 0, and after each layer's last weight word row/wnum are back at
    // 0, which is exactly the starting point of the following phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            row      <= '0;
            wnum     <= '0;
            layer    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        word_cnt <= '0;
                        row      <= '0;
                        wnum     <= '0;
                        layer    <= '0;
                    end
                end
                ST_LOAD_IN: begin
                    if (accept) begin
                        word_cnt <= word_cnt + 3'd1;
                        if (word_cnt == LAST_WORD) row <= row + 4'd1;
                    end
                end
                ST_LOAD_W: begin
                    if (accept) begin
                        row <= row + 4'd1;
                        if (row == LAST_ROW) wnum <= wnum + 3'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_done && (layer != LAST_LAYER)) layer <= layer + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Gap and result counters
    // -------------------------------------------------------------------------
    counter #(
        .WIDTH (GAP_W)
    ) u_gap_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (gap_clr),
        .en    (gap_en),
        .count (gap_cnt)
    );

    counter #(
        .WIDTH (8)
    ) u_result_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (res_clr),
        .en    (res_en),
        .count (res_cnt)
    );

    // -------------------------------------------------------------------------
    // Registered load interface
    // -------------------------------------------------------------------------
    // The control fields capture the counters of the accepted word (the
    // pre-increment values). Payload and fields only load on a transfer and
    // otherwise hold their last value.
    // NOTE: payload and control fields are reset as well as load_en_o, since
    // every output must read 0 out of reset; a register that only ever feeds
    // logic qualified by load_en_o could otherwise skip the reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_en_o           <= 1'b0;
            load_payload_o      <= '0;
            load_type_o         <= 1'b0;
            input_load_number_o <= '0;
            layer_number_o      <= '0;
            weight_number_o     <= '0;
        end else begin
            load_en_o <= accept;
            if (accept) begin
                load_payload_o      <= s_data_i;
                load_type_o         <= (state == ST_LOAD_IN) ? LOAD_TYPE_INPUT : LOAD_TYPE_WEIGHT;
                input_load_number_o <= row;
                // Input words always belong to layer 0.
                layer_number_o      <= (state == ST_LOAD_IN) ? 3'd0 : layer;
                weight_number_o     <= wnum;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Completion pulse
    // -------------------------------------------------------------------------
    // Registered so it appears the cycle after the final result beat, which is
    // also the first IDLE cycle, so busy_o falls in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_o <= 1'b0;
        end else begin
            done_o <= res_done;
        end
    end

endmodule

// File: tb/tb_mlp_load_sequencer.sv
`timescale 1ns/1ps
module tb_mlp_load_sequencer;

    localparam int NUM_LAYERS   = 8;
    localparam int LAYER_GAP    = 4;
    localparam int RESULT_WORDS = 128;
    localparam int IN_BEATS     = 128;
    localparam int W_BEATS      = 128;
    localparam int JOB_BEATS    = IN_BEATS + NUM_LAYERS * W_BEATS;
    localparam logic [31:0] DATA_BASE = 32'hA500_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [31:0] s_data_i = 32'd0;
    logic        load_en_o;
    logic [31:0] load_payload_o;
    logic        load_type_o;
    logic [3:0]  input_load_number_o;
    logic [2:0]  layer_number_o;
    logic [2:0]  weight_number_o;
    logic        result_valid_i = 1'b0;

    always #5 clk = ~clk;

    mlp_load_sequencer #(
        .NUM_LAYERS   (NUM_LAYERS),
        .LAYER_GAP    (LAYER_GAP),
        .RESULT_WORDS (RESULT_WORDS)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .s_valid_i           (s_valid_i),
        .s_ready_o           (s_ready_o),
        .s_data_i            (s_data_i),
        .load_en_o           (load_en_o),
        .load_payload_o      (load_payload_o),
        .load_type_o         (load_type_o),
        .input_load_number_o (input_load_number_o),
        .layer_number_o      (layer_number_o),
        .weight_number_o     (weight_number_o),
        .result_valid_i      (result_valid_i)
    );

    // fields = {load_type, row[3:0], layer[2:0], wnum[2:0]}
    typedef struct {
        logic [31:0] payload;
        logic [10:0] fields;
        int          cyc;
    } beat_t;

    beat_t beats[$];
    beat_t mon_b;
    int    cyc        = 0;
    int    done_seen  = 0;
    int    total      = 0;
    int    bad        = 0;
    int    sent       = 0;
    int    valid_mode = 0;   // 0 idle, 1 always valid, 2 random 50%

    // Monitor: samples on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (load_en_o) begin
            mon_b.payload = load_payload_o;
            mon_b.fields  = {load_type_o, input_load_number_o, layer_number_o, weight_number_o};
            mon_b.cyc     = cyc;
            beats.push_back(mon_b);
        end
        if (done_o) done_seen++;
    end

    // Host: drives valid/data after the main sequence has settled rst.
    // The word on s_data_i is always DATA_BASE + number of words accepted so far.
    always @(negedge clk) begin
        #2;
        case (valid_mode)
            0:       s_valid_i = 1'b0;
            1:       s_valid_i = 1'b1;
            default: s_valid_i = ($urandom_range(0, 1) != 0);
        endcase
        s_data_i = DATA_BASE + 32'(sent);
        if (s_valid_i && s_ready_o && !rst) sent++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference order of the load fields for beat k of a job.
    function automatic logic [10:0] exp_fields(input int k);
        int j;
        if (k < IN_BEATS) return {1'b1, 4'(k / 8), 3'd0, 3'd0};
        j = k - IN_BEATS;
        return {1'b0, 4'(j % 16), 3'(j / W_BEATS), 3'((j % W_BEATS) / 16)};
    endfunction

    task automatic wait_beats(input string tag, input int n, input int limit);
        int i;
        i = 0;
        while (beats.size() < n && i < limit) begin
            tick();
            i++;
        end
        check(tag, 32'(beats.size() >= n), 32'd1);
    endtask

    task automatic verify_job(input string tag, input int base, input bit check_gaps);
        int d;
        int e;
        check({tag, "_beat_count"}, 32'(beats.size()), 32'(JOB_BEATS));
        for (int k = 0; k < beats.size() && k < JOB_BEATS; k++) begin
            check({tag, "_fields"}, 32'(beats[k].fields), 32'(exp_fields(k)));
            check({tag, "_payload"}, beats[k].payload, DATA_BASE + 32'(base + k));
        end
        if (check_gaps && beats.size() >= JOB_BEATS) begin
            for (int k = 1; k < JOB_BEATS; k++) begin
                d = beats[k].cyc - beats[k-1].cyc;
                e = (k >= IN_BEATS + W_BEATS && (k - IN_BEATS) % W_BEATS == 0) ? LAYER_GAP + 1 : 1;
                check({tag, "_spacing"}, 32'(d), 32'(e));
            end
        end
    endtask

    int job_base;
    int done_before;

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy",    32'(busy_o),    32'd0);
        check("rst_done",    32'(done_o),    32'd0);
        check("rst_ready",   32'(s_ready_o), 32'd0);
        check("rst_load_en", 32'(load_en_o), 32'd0);
        check("rst_payload", load_payload_o, 32'd0);
        check("rst_fields",  32'({load_type_o, input_load_number_o, layer_number_o, weight_number_o}), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_ready", 32'(s_ready_o), 32'd0);
        check("idle_busy",  32'(busy_o),    32'd0);

        // ---------------- job 1: no stalls ----------------
        valid_mode = 1;
        tick();
        check("idle_no_accept", 32'(beats.size()), 32'd0);
        job_base = sent;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("job1_busy_after_start", 32'(busy_o), 32'd1);
        check("job1_ready_load_in",    32'(s_ready_o), 32'd1);
        wait_beats("job1_loads", JOB_BEATS, 3000);
        check("job1_last_load_en", 32'(load_en_o), 32'd1);
        // Result beats during the final gap must be ignored.
        result_valid_i = 1'b1;
        tick();
        check("gap_load_en",      32'(load_en_o), 32'd0);
        check("gap_payload_hold", load_payload_o, DATA_BASE + 32'(job_base + JOB_BEATS - 1));
        check("gap_fields_hold",  32'({load_type_o, input_load_number_o, layer_number_o, weight_number_o}),
              32'({1'b0, 4'd15, 3'd7, 3'd7}));
        check("gap_ready",        32'(s_ready_o), 32'd0);
        check("gap_busy",         32'(busy_o),    32'd1);
        tick();
        result_valid_i = 1'b0;
        tick();
        tick();
        // Now in WAIT_RES: 127 beats with one stall, no done yet.
        done_before = done_seen;
        for (int i = 0; i < RESULT_WORDS - 1; i++) begin
            if (i == 60) begin
                result_valid_i = 1'b0;
                tick();
            end
            result_valid_i = 1'b1;
            tick();
        end
        result_valid_i = 1'b0;
        tick();
        check("job1_no_early_done", 32'(done_seen - done_before), 32'd0);
        check("job1_busy_waiting",  32'(busy_o), 32'd1);
        check("job1_no_extra_beats", 32'(beats.size()), 32'(JOB_BEATS));
        result_valid_i = 1'b1;
        tick();
        result_valid_i = 1'b0;
        check("job1_done_pulse", 32'(done_o), 32'd1);
        check("job1_busy_low",   32'(busy_o), 32'd0);

        verify_job("job1", job_base, 1'b1);
        check("wrap_input_word8",    32'(beats[8].fields),   32'({1'b1, 4'd1, 3'd0, 3'd0}));
        check("first_weight_word",   32'(beats[128].fields), 32'({1'b0, 4'd0, 3'd0, 3'd0}));
        check("layer3_weight_word17", 32'(beats[IN_BEATS + 3 * W_BEATS + 16].fields),
              32'({1'b0, 4'd0, 3'd3, 3'd1}));
        check("last_weight_word",    32'(beats[JOB_BEATS - 1].fields), 32'({1'b0, 4'd15, 3'd7, 3'd7}));

        // ---------------- job 2: start in done cycle, random stalls ----------------
        valid_mode = 2;
        beats.delete();
        job_base = sent;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("job2_start_in_done_cycle", 32'(busy_o), 32'd1);
        check("job2_done_cleared",        32'(done_o), 32'd0);
        wait_beats("job2_into_load_w", 300, 4000);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("job2_busy_after_ignored_start", 32'(busy_o), 32'd1);
        wait_beats("job2_loads", JOB_BEATS, 8000);
        repeat (6) tick();
        check("job2_ready_waiting", 32'(s_ready_o), 32'd0);
        done_before = done_seen;
        for (int i = 0; i < RESULT_WORDS - 1; i++) begin
            result_valid_i = 1'b1;
            tick();
        end
        check("job2_no_early_done", 32'(done_seen - done_before), 32'd0);
        tick();
        result_valid_i = 1'b0;
        check("job2_done_pulse", 32'(done_o), 32'd1);
        check("job2_busy_low",   32'(busy_o), 32'd0);
        verify_job("job2", job_base, 1'b0);
        tick();
        check("job2_done_one_cycle", 32'(done_o), 32'd0);

        // ---------------- job 3: reset during layer 2 ----------------
        valid_mode = 1;
        beats.delete();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_beats("job3_layer2", IN_BEATS + 2 * W_BEATS + 10, 1000);
        done_before = done_seen;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_load_en", 32'(load_en_o), 32'd0);
        check("midrst_payload", load_payload_o, 32'd0);
        check("midrst_fields",  32'({load_type_o, input_load_number_o, layer_number_o, weight_number_o}), 32'd0);
        check("midrst_busy",    32'(busy_o),    32'd0);
        check("midrst_ready",   32'(s_ready_o), 32'd0);
        check("midrst_done",    32'(done_o),    32'd0);
        tick();
        tick();
        check("midrst_stays_idle", 32'(busy_o), 32'd0);
        beats.delete();
        job_base = sent;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_beats("job4_restart", 9, 200);
        check("restart_first_fields",  32'(beats[0].fields), 32'({1'b1, 4'd0, 3'd0, 3'd0}));
        check("restart_first_payload", beats[0].payload, DATA_BASE + 32'(job_base));
        check("restart_word8_row",     32'(beats[8].fields), 32'({1'b1, 4'd1, 3'd0, 3'd0}));
        check("midrst_no_done",        32'(done_seen - done_before), 32'd0);
        valid_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mlp_load_sequencer.md
# mlp_load_sequencer

Upstream control stage for `MLP_acc_top`. It accepts a 32-bit valid/ready word stream from the host and drives the accelerator's load interface with correctly sequenced control fields:

- the layer-0 input matrix;
- eight layers of weights, with `load_type`, `input_load_number`, `layer_number` and `weight_number` set for each word.

After the last layer it counts the accelerator's result words and pulses `done_o`.

## Interface
Parameters:
- NUM_LAYERS, 8, layers run per job (1..8)
- LAYER_GAP, 4, idle cycles inserted after each layer's last weight word (pipeline drain)
- RESULT_WORDS, 128, `result_valid_i` beats that end a job

Ports:
- clk  in  1  clock; the block has one clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  job start; sampled only in IDLE
- busy_o  out  1  high from the cycle after an accepted start until `done_o`
- done_o  out  1  one-cycle pulse when the job completes
- s_valid_i  in  1  host word valid
- s_ready_o  out  1  sequencer can accept a word
- s_data_i  in  32  host word: packed input pair or weight pair
- load_en_o  out  1  to `load_en_i`
- load_payload_o  out  32  to `load_payload_i`
- load_type_o  out  1  1 = input, 0 = weight
- input_load_number_o  out  4  row index 0..15
- layer_number_o  out  3  layer 0..7
- weight_number_o  out  3  weight group 0..7
- result_valid_i  in  1  from `result_valid_o`

## Operation
- Handshake: a word transfers when `s_valid_i && s_ready_o`.
  - `s_ready_o = 1` only in LOAD_IN and LOAD_W.
  - `s_ready_o` is combinational from state only, never from `s_valid_i`.
- FSM states: IDLE, LOAD_IN, LOAD_W, GAP, WAIT_RES.
- IDLE:
  - `start_i` clears all counters and sets layer = 0.
  - Next state is LOAD_IN.
- LOAD_IN (128 words):
  - 16 rows of 8 words each; `load_type_o = 1`, `layer_number_o = 0`, `input_load_number_o = row`.
  - `word_cnt` (3 bits) increments per transfer; `row` increments when `word_cnt` wraps from 7 to 0.
  - After row 15 word 7 the FSM enters LOAD_W with `wnum = 0` and `row = 0`.
- LOAD_W (128 words per layer):
  - Ordering: for `wnum` 0..7, `row` 0..15, one word each; `load_type_o = 0`.
  - `row` increments per transfer; `wnum` increments when `row` wraps from 15.
  - After `wnum = 7`, `row = 15` the FSM enters GAP.
- GAP:
  - Count LAYER_GAP cycles. `load_en_o = 0` and `s_ready_o = 0` throughout.
  - If `layer == NUM_LAYERS-1`, go to WAIT_RES; otherwise increment `layer` and go to LOAD_W.
  - Input words are loaded for layer 0 only. Later layers take their input from the accelerator's internal result buffer.
- WAIT_RES:
  - Count cycles with `result_valid_i = 1`.
  - When the count reaches RESULT_WORDS, pulse `done_o`, clear `busy_o` and return to IDLE.
- Stalls: when `s_valid_i = 0` in a load state, counters hold and `load_en_o` is 0 the next cycle. Gaps between words are allowed anywhere.
- Counter widths:
  - `word_cnt` 3 bits, `row` 4 bits, `wnum` 3 bits, `layer` 3 bits.
  - Gap counter is `$clog2(LAYER_GAP+1)` bits; result counter is 8 bits.
  - All counters wrap naturally and are never saturated.
- `start_i` outside IDLE is ignored.
- `result_valid_i` outside WAIT_RES is ignored.

## Timing
- Reset values: every output is 0; state is IDLE.
- Load outputs are registered and appear exactly 1 cycle after the transfer cycle:
  - `load_en_o` goes high and `load_payload_o` carries `s_data_i`;
  - the control fields carry the counter values of the accepted word, not the post-increment values.
- `load_en_o` is high for exactly one cycle per transferred word.
- A back-to-back transfer stream gives continuous `load_en_o`.
- Payload and control outputs hold their last value when `load_en_o = 0`.
- After the last weight word of a layer, exactly LAYER_GAP cycles pass with `s_ready_o = 0` before the next layer's first acceptance.
- Pulse and busy timing:
  - `done_o` is asserted in the cycle after the RESULT_WORDS-th `result_valid_i` beat.
  - `busy_o` falls in the same cycle as `done_o`.
  - `start_i` in the `done_o` cycle is accepted, since the FSM is already in IDLE.
- Minimum job length: 128 + NUM_LAYERS×(128 + LAYER_GAP) transfer/idle cycles, plus the result wait.
- Reset mid-job returns to IDLE in the next cycle:
  - `load_en_o` drops and no `done_o` is issued;
  - a word presented during the reset cycle is not accepted.

## Structure
- Shared package `mlp_pkg`:
  - FSM state enum `seq_state_t`;
  - constants `ROWS = 16`, `WORDS_PER_ROW = 8`, `WEIGHT_GROUPS = 8`, `LOAD_TYPE_INPUT = 1'b1`, `LOAD_TYPE_WEIGHT = 1'b0`.
- The gap and result counters reuse the existing `counter` module: one instance each, enabled by state, with the counter cleared on state entry.
- No other sub-modules.

## Test plan
- **Full job, no stalls:** reset, `start_i`, continuous `s_valid_i`, NUM_LAYERS=8, LAYER_GAP=4.
  - Expect 128 `load_type = 1` beats, then 8×128 `load_type = 0` beats, with 4-cycle gaps between layers.
  - Word 129 has `layer = 0`, `wnum = 0`, `row = 0`; the last weight beat has `layer = 7`, `wnum = 7`, `row = 15`.
- **Random stalls:** `s_valid_i` random at 50%.
  - The `load_en_o` beat count and field sequence are identical to the no-stall run.
  - Payload equals host data in order.
- **Row / group wrap:** word 8 of the input phase carries `row = 1`; weight word 17 of layer 3 carries `wnum = 1`, `row = 0`, `layer = 3`.
- **Completion:** in WAIT_RES drive 127 `result_valid_i` beats and no `done_o` appears; the 128th beat gives `done_o = 1` one cycle later and `busy_o = 0`.
- **Ignored start:** `start_i` pulsed during LOAD_W changes no counter and produces no extra beats.
- **Reset mid-job:** assert `rst` during layer 2.
  - The next cycle shows all outputs at 0 and state IDLE.
  - A new `start_i` restarts from `load_type = 1`, `row = 0`.
